// File: rtl/line_mem_responder.sv
// Memory-side responder for whole-line (8 x 32-bit) reads and writes behind a data cache.
// A request waits LATENCY cycles, moves one word per cycle, then pulses resp_valid for one cycle.
module line_mem_responder #(
  parameter int LATENCY     = 4,
  parameter int DEPTH_WORDS = 1024,
  parameter int LINE_WORDS  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [31:0]               req_addr,
  input  logic [32*LINE_WORDS-1:0]  req_wdata,
  output logic                      resp_valid,
  output logic [32*LINE_WORDS-1:0]  resp_rdata,
  output logic                      busy
);

  // state  | meaning
  // IDLE   | ready for a request
  // WAIT   | access latency countdown
  // XFER   | one word beat per cycle, beats 0..7
  // DONE   | one-cycle completion pulse
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_XFER = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam int          LB        = 32 * LINE_WORDS;
  localparam logic [15:0] WAIT_INIT = (LATENCY > 0) ? 16'(LATENCY - 1) : 16'd0;
  localparam logic [2:0]  LAST_BEAT = 3'(LINE_WORDS - 1);

  logic [1:0]    state;
  logic [15:0]   wait_cnt;
  logic [2:0]    beat;
  logic          we_q;
  logic [26:0]   line_q;
  logic [LB-1:0] wdata_q;
  logic [LB-1:0] rbuf;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [29:0]   word_full;
  logic [AW-1:0] idx;
  logic [31:0]   rd_word;
  logic [31:0]   wr_word;
  logic          accept;
  logic          unused_bits;

  // Upper line-address bits alias onto the array; the byte offset is never used.
  assign word_full   = {line_q, beat};
  assign idx         = word_full[AW-1:0];
  assign unused_bits = ^{req_addr[4:0], word_full[29:AW]};
  assign rd_word     = mem[idx];
  assign wr_word     = wdata_q[32*beat +: 32];

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_DONE);
  assign busy       = (state != S_IDLE);
  assign accept     = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      wait_cnt   <= 16'd0;
      beat       <= 3'd0;
      we_q       <= 1'b0;
      line_q     <= 27'd0;
      wdata_q    <= '0;
      rbuf       <= '0;
      resp_rdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            we_q    <= req_we;
            line_q  <= req_addr[31:5];
            wdata_q <= req_wdata;
            beat    <= 3'd0;
            if (LATENCY == 0) begin
              state <= S_XFER;
            end else begin
              state    <= S_WAIT;
              wait_cnt <= WAIT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == 16'd0) state <= S_XFER;
          else                   wait_cnt <= wait_cnt - 16'd1;
        end
        S_XFER: begin
          if (!we_q) rbuf[32*beat +: 32] <= rd_word;
          beat <= beat + 3'd1;
          if (beat == LAST_BEAT) begin
            state      <= S_DONE;
            // the last read word bypasses the buffer so DONE already shows the full line
            resp_rdata <= we_q ? wdata_q : {rd_word, rbuf[LB-33:0]};
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Backing array has no reset: an aborted write keeps only its completed beats.
  always_ff @(posedge clk) begin
    if (state == S_XFER && we_q) mem[idx] <= wr_word;
  end

endmodule

// File: tb/tb_line_mem_responder.sv
// Self-checking bench for line_mem_responder: LATENCY=4 and LATENCY=0 instances against a word-array model.
module tb_line_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [1:0]   req_valid, req_ready, req_we, resp_valid, busy;
  logic [31:0]  req_addr  [2];
  logic [255:0] req_wdata [2];
  logic [255:0] resp_rdata[2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mdl [2][1024];

  line_mem_responder #(.LATENCY(4), .DEPTH_WORDS(1024), .LINE_WORDS(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .busy(busy[0]));

  line_mem_responder #(.LATENCY(0), .DEPTH_WORDS(1024), .LINE_WORDS(8)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .busy(busy[1]));

  function automatic int word_idx(input logic [31:0] addr, input int k);
    int unsigned line_no;
    line_no = addr >> 5;
    return int'((line_no * 8 + k) % 1024);
  endfunction

  function automatic logic [255:0] mdl_line(input int s, input logic [31:0] addr);
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = mdl[s][word_idx(addr, k)];
    return r;
  endfunction

  function automatic void mdl_write(input int s, input logic [31:0] addr, input logic [255:0] wd);
    for (int k = 0; k < 8; k++) mdl[s][word_idx(addr, k)] = wd[32*k +: 32];
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  // Issues one request, scrambles req_* after acceptance and measures the response.
  task automatic do_req(input int s, input logic we, input logic [31:0] addr, input logic [255:0] wd,
                        output logic [255:0] rd, output int edges, output int rdy_low,
                        output int busy_cnt, output int pulses);
    int e0;
    bit seen;
    rd = '0; edges = -1; rdy_low = 0; busy_cnt = 0; pulses = 0; seen = 0;
    @(negedge clk);
    for (int n = 0; n < 100 && !req_ready[s]; n++) @(negedge clk);
    req_valid[s] = 1'b1; req_we[s] = we; req_addr[s] = addr; req_wdata[s] = wd;
    @(posedge clk);
    e0 = cyc + 1;
    #1;
    req_valid[s] = 1'b0; req_we[s] = ~we; req_addr[s] = 32'hFFFF_FFFF; req_wdata[s] = rand_line();
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (!req_ready[s]) rdy_low++;
      if (busy[s]) busy_cnt++;
      if (resp_valid[s]) begin
        pulses++;
        if (!seen) begin edges = cyc - e0; rd = resp_rdata[s]; seen = 1; end
      end
      if (seen && req_ready[s]) break;
    end
  endtask

  task automatic test_reset();
    #12;
    total++; if (req_ready !== 2'b11) begin bad++; $display("FAIL reset_ready got=%b exp=11", req_ready); end
    total++; if (resp_valid !== 2'b00) begin bad++; $display("FAIL reset_resp_valid got=%b exp=00", resp_valid); end
    total++; if (busy !== 2'b00) begin bad++; $display("FAIL reset_busy got=%b exp=00", busy); end
    total++; if (resp_rdata[0] !== 256'd0 || resp_rdata[1] !== 256'd0) begin
      bad++; $display("FAIL reset_rdata got=%h exp=0", resp_rdata[0]);
    end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_basic();
    logic [255:0] wd, rd, exp;
    int e, rl, bc, p;
    for (int k = 0; k < 8; k++) wd[32*k +: 32] = 32'hA000_0000 + k;
    exp = wd;
    do_req(0, 1'b1, 32'h40, wd, rd, e, rl, bc, p);
    mdl_write(0, 32'h40, wd);
    total++; if (e !== 12) begin bad++; $display("FAIL write_latency got=%0d exp=12", e); end
    total++; if (rl !== 13) begin bad++; $display("FAIL write_ready_low got=%0d exp=13", rl); end
    total++; if (rd !== wd) begin bad++; $display("FAIL write_echo got=%h exp=%h", rd, wd); end
    total++; if (p !== 1) begin bad++; $display("FAIL write_pulses got=%0d exp=1", p); end
    do_req(0, 1'b0, 32'h40, '0, rd, e, rl, bc, p);
    total++; if (rd !== exp) begin bad++; $display("FAIL read_line got=%h exp=%h", rd, exp); end
    total++; if (e !== 12) begin bad++; $display("FAIL read_latency got=%0d exp=12", e); end
    total++; if (rl !== 13) begin bad++; $display("FAIL read_ready_low got=%0d exp=13", rl); end
    total++; if (bc !== 13) begin bad++; $display("FAIL read_busy got=%0d exp=13", bc); end
  endtask

  task automatic test_unaligned();
    logic [255:0] rd, exp;
    int e, rl, bc, p;
    exp = mdl_line(0, 32'h40);
    do_req(0, 1'b0, 32'h5C, '0, rd, e, rl, bc, p);
    total++; if (rd !== exp) begin bad++; $display("FAIL unaligned_read got=%h exp=%h", rd, exp); end
  endtask

  task automatic test_back_to_back();
    logic [255:0] wd, rd2;
    int e0, acc2, p1, p2, pulses;
    wd = rand_line();
    acc2 = -1; p1 = -1; p2 = -1; pulses = 0; rd2 = '0;
    @(negedge clk);
    for (int n = 0; n < 100 && !req_ready[0]; n++) @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h80; req_wdata[0] = wd;
    @(posedge clk);
    e0 = cyc + 1;
    #1 req_we[0] = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (acc2 >= 0 && cyc == acc2) req_valid[0] = 1'b0;
      if (resp_valid[0]) begin
        pulses++;
        if (p1 < 0) p1 = cyc - e0;
        else begin p2 = cyc - acc2; rd2 = resp_rdata[0]; end
      end
      if (acc2 < 0 && req_valid[0] && req_ready[0]) acc2 = cyc + 1;
    end
    req_valid[0] = 1'b0;
    mdl_write(0, 32'h80, wd);
    total++; if (acc2 - e0 !== 14) begin bad++; $display("FAIL b2b_spacing got=%0d exp=14", acc2 - e0); end
    total++; if (pulses !== 2) begin bad++; $display("FAIL b2b_pulses got=%0d exp=2", pulses); end
    total++; if (p1 !== 12 || p2 !== 12) begin bad++; $display("FAIL b2b_latency got=%0d,%0d exp=12,12", p1, p2); end
    total++; if (rd2 !== wd) begin bad++; $display("FAIL b2b_readback got=%h exp=%h", rd2, wd); end
  endtask

  task automatic test_reset_mid();
    logic [255:0] rd, wd, exp;
    int e, rl, bc, p, pulses;
    do_req(0, 1'b1, 32'hC0, '0, rd, e, rl, bc, p);
    mdl_write(0, 32'hC0, '0);
    wd = {8{32'h5555_5555}};
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'hC0; req_wdata[0] = wd;
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    total++; if (busy[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
      bad++; $display("FAIL abort_idle got busy=%b ready=%b exp busy=0 ready=1", busy[0], req_ready[0]);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int n = 0; n < 20; n++) begin @(negedge clk); if (resp_valid[0]) pulses++; end
    total++; if (pulses !== 0) begin bad++; $display("FAIL abort_no_resp got=%0d exp=0", pulses); end
    for (int k = 0; k < 3; k++) mdl[0][word_idx(32'hC0, k)] = 32'h5555_5555;
    exp = {160'd0, {3{32'h5555_5555}}};
    do_req(0, 1'b0, 32'hC0, '0, rd, e, rl, bc, p);
    total++; if (rd !== exp) begin bad++; $display("FAIL abort_partial got=%h exp=%h", rd, exp); end
    total++; if (rd !== mdl_line(0, 32'hC0)) begin bad++; $display("FAIL abort_model got=%h", rd); end
  endtask

  task automatic test_wrap();
    logic [255:0] rd;
    int e, rl, bc, p;
    do_req(0, 1'b1, 32'h1000, {8{32'hDEAD_BEEF}}, rd, e, rl, bc, p);
    mdl_write(0, 32'h1000, {8{32'hDEAD_BEEF}});
    do_req(0, 1'b0, 32'h0, '0, rd, e, rl, bc, p);
    total++; if (rd !== {8{32'hDEAD_BEEF}}) begin bad++; $display("FAIL wrap_read got=%h exp=deadbeef x8", rd); end
  endtask

  task automatic test_random();
    logic [31:0]  pool [6];
    bit           wr   [6];
    logic [255:0] rd, wd, exp;
    logic         we;
    int e, rl, bc, p, j;
    for (int i = 0; i < 6; i++) begin pool[i] = $urandom; wr[i] = 0; end
    for (int it = 0; it < 24; it++) begin
      j  = $urandom_range(0, 5);
      we = wr[j] ? 1'($urandom_range(0, 1)) : 1'b1;
      // alias via random upper bits and offset, same word index modulo the array
      pool[j] = {pool[j][31:15] + 17'($urandom_range(0, 3)) * 17'd1, pool[j][14:5], 5'($urandom)};
      wd = rand_line();
      exp = we ? wd : mdl_line(0, pool[j]);
      do_req(0, we, pool[j], wd, rd, e, rl, bc, p);
      if (we) begin mdl_write(0, pool[j], wd); wr[j] = 1; end
      total++; if (rd !== exp) begin bad++; $display("FAIL random_%0d we=%0b got=%h exp=%h", it, we, rd, exp); end
      total++; if (e !== 12) begin bad++; $display("FAIL random_lat_%0d got=%0d exp=12", it, e); end
    end
  endtask

  task automatic test_lat0();
    logic [255:0] rd, wd;
    logic [31:0] a;
    int e, rl, bc, p;
    a = $urandom; wd = rand_line();
    do_req(1, 1'b1, a, wd, rd, e, rl, bc, p);
    mdl_write(1, a, wd);
    total++; if (e !== 8) begin bad++; $display("FAIL lat0_write_latency got=%0d exp=8", e); end
    do_req(1, 1'b0, a, '0, rd, e, rl, bc, p);
    total++; if (rd !== mdl_line(1, a)) begin bad++; $display("FAIL lat0_read got=%h exp=%h", rd, mdl_line(1, a)); end
    total++; if (e !== 8) begin bad++; $display("FAIL lat0_read_latency got=%0d exp=8", e); end
    total++; if (bc !== 9) begin bad++; $display("FAIL lat0_busy got=%0d exp=9", bc); end
    total++; if (rl !== 9) begin bad++; $display("FAIL lat0_ready_low got=%0d exp=9", rl); end
  endtask

  initial begin
    rst = 1'b0;
    req_valid = '0; req_we = '0;
    for (int s = 0; s < 2; s++) begin req_addr[s] = '0; req_wdata[s] = '0; end
    test_reset();
    test_basic();
    test_unaligned();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    test_random();
    test_lat0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
